// File: rtl/frogger_player_ctrl.sv
// Frogger player controller: turns switch edges into grid moves, carries the frog
// on logs, and tracks deaths, lives, lily pads, score and level completion.
module frogger_player_ctrl #(
    parameter int GRID_W       = 14,
    parameter int GRID_H       = 15,
    parameter int START_X      = 10,
    parameter int START_Y      = 14,
    parameter int N_LIVES      = 3,
    parameter int N_PADS       = 5,
    parameter int DRIFT_DIV    = 39000000,
    parameter int DEATH_CYCLES = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Game_Active,
    input  logic              i_Up_Mvt,
    input  logic              i_Down_Mvt,
    input  logic              i_Left_Mvt,
    input  logic              i_Right_Mvt,
    input  logic              i_Collided,
    input  logic [3:0]        i_Bitmap_Data,
    input  logic              i_On_Log,
    input  logic              i_Log_Dir,
    input  logic [2:0]        i_Pad_Idx,
    output logic [5:0]        o_Frogger_X,
    output logic [5:0]        o_Frogger_Y,
    output logic [6:0]        o_Score,
    output logic [2:0]        o_Lives,
    output logic [N_PADS-1:0] o_Pads_Filled,
    output logic              o_Dying,
    output logic              o_Game_Over,
    output logic              o_Level_Clear
);

    localparam int DRIFT_W = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
    localparam int DEATH_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAY      = 2'd1;
    localparam logic [1:0] ST_DYING     = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    localparam logic [5:0]         START_X_C  = 6'(START_X);
    localparam logic [5:0]         START_Y_C  = 6'(START_Y);
    localparam logic [5:0]         X_MAX      = 6'(GRID_W - 1);
    localparam logic [5:0]         Y_MAX      = 6'(GRID_H - 1);
    localparam logic [2:0]         LIVES_C    = 3'(N_LIVES);
    localparam logic [DRIFT_W-1:0] DRIFT_LAST = DRIFT_W'(DRIFT_DIV - 1);
    localparam logic [DRIFT_W-1:0] DRIFT_ZERO = DRIFT_W'(0);
    localparam logic [DRIFT_W-1:0] DRIFT_ONE  = DRIFT_W'(1);
    localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_CYCLES - 1);
    localparam logic [DEATH_W-1:0] DEATH_ZERO = DEATH_W'(0);
    localparam logic [DEATH_W-1:0] DEATH_ONE  = DEATH_W'(1);
    localparam logic [N_PADS-1:0]  PADS_ALL   = {N_PADS{1'b1}};
    localparam logic [N_PADS-1:0]  PADS_NONE  = {N_PADS{1'b0}};

    logic [1:0]         state_r, state_s;
    logic [5:0]         x_r, x_s, y_r, y_s;
    logic [6:0]         score_r, score_s;
    logic [2:0]         lives_r, lives_s;
    logic [N_PADS-1:0]  pads_r, pads_s, pad_bit_s;
    logic [DRIFT_W-1:0] drift_r, drift_s;
    logic [DEATH_W-1:0] death_cnt_r, death_cnt_s;
    logic [3:0]         sw_r, sw_s, edge_s;
    logic               level_clear_r, level_clear_s;
    logic               dying_r, game_over_r;
    logic               hazard_s, land_ok_s, kill_s;

    // Next-state and datapath decisions; in PLAY only the highest-priority action applies.
    always_comb begin
        sw_s          = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
        edge_s        = sw_s & ~sw_r;
        // An out-of-range pad index shifts the bit out, which then reads as a bad landing.
        pad_bit_s     = N_PADS'(1'b1) << i_Pad_Idx;
        hazard_s      = i_Collided || ((i_Bitmap_Data == 4'd2) && !i_On_Log);
        land_ok_s     = (i_Bitmap_Data == 4'd4) && (pad_bit_s != PADS_NONE) &&
                        ((pads_r & pad_bit_s) == PADS_NONE);
        state_s       = state_r;
        x_s           = x_r;
        y_s           = y_r;
        score_s       = score_r;
        lives_s       = lives_r;
        pads_s        = pads_r;
        drift_s       = drift_r;
        death_cnt_s   = death_cnt_r;
        level_clear_s = 1'b0;
        kill_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                drift_s = DRIFT_ZERO;
                if (i_Game_Active) begin
                    state_s = ST_PLAY;
                    x_s     = START_X_C;
                    y_s     = START_Y_C;
                    score_s = 7'd0;
                    lives_s = LIVES_C;
                    pads_s  = PADS_NONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!i_Game_Active) begin
                    state_s = ST_IDLE;
                end else begin
                    if (i_On_Log) begin
                        drift_s = (drift_r == DRIFT_LAST) ? DRIFT_ZERO : drift_r + DRIFT_ONE;
                    end else begin
                        drift_s = DRIFT_ZERO;
                    end
                    if (hazard_s) begin
                        kill_s = 1'b1;
                    end else if (y_r == 6'd0) begin
                        if (land_ok_s) begin
                            score_s = (score_r == 7'd127) ? 7'd127 : score_r + 7'd1;
                            x_s     = START_X_C;
                            y_s     = START_Y_C;
                            if ((pads_r | pad_bit_s) == PADS_ALL) begin
                                pads_s        = PADS_NONE;
                                level_clear_s = 1'b1;
                            end else begin
                                pads_s = pads_r | pad_bit_s;
                            end
                        end else begin
                            kill_s = 1'b1;
                        end
                    end else if (i_On_Log && (drift_r == DRIFT_LAST)) begin
                        // Logs never wrap the frog around the screen edge.
                        if (i_Log_Dir) begin
                            if (x_r == X_MAX) kill_s = 1'b1;
                            else              x_s = x_r + 6'd1;
                        end else begin
                            if (x_r == 6'd0) kill_s = 1'b1;
                            else             x_s = x_r - 6'd1;
                        end
                    end else if (edge_s[3]) begin
                        y_s = (y_r != 6'd0) ? y_r - 6'd1 : y_r;
                    end else if (edge_s[2]) begin
                        y_s = (y_r != Y_MAX) ? y_r + 6'd1 : y_r;
                    end else if (edge_s[1]) begin
                        x_s = (x_r != 6'd0) ? x_r - 6'd1 : x_r;
                    end else if (edge_s[0]) begin
                        x_s = (x_r != X_MAX) ? x_r + 6'd1 : x_r;
                    end else begin
                        x_s = x_r;
                    end
                end
            end
            ST_DYING: begin
                drift_s = DRIFT_ZERO;
                if (!i_Game_Active) begin
                    state_s = ST_IDLE;
                end else if (death_cnt_r == DEATH_LAST) begin
                    if (lives_r == 3'd0) begin
                        state_s = ST_GAME_OVER;
                    end else begin
                        state_s = ST_PLAY;
                        x_s     = START_X_C;
                        y_s     = START_Y_C;
                    end
                end else begin
                    death_cnt_s = death_cnt_r + DEATH_ONE;
                end
            end
            ST_GAME_OVER: begin
                drift_s = DRIFT_ZERO;
                if (!i_Game_Active) state_s = ST_IDLE;
                else                state_s = ST_GAME_OVER;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (kill_s) begin
            lives_s     = lives_r - 3'd1;
            state_s     = ST_DYING;
            death_cnt_s = DEATH_ZERO;
        end else begin
            death_cnt_s = death_cnt_s;
        end
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r       <= ST_IDLE;
            x_r           <= START_X_C;
            y_r           <= START_Y_C;
            score_r       <= 7'd0;
            lives_r       <= LIVES_C;
            pads_r        <= PADS_NONE;
            drift_r       <= DRIFT_ZERO;
            death_cnt_r   <= DEATH_ZERO;
            sw_r          <= 4'd0;
            level_clear_r <= 1'b0;
            dying_r       <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            x_r           <= x_s;
            y_r           <= y_s;
            score_r       <= score_s;
            lives_r       <= lives_s;
            pads_r        <= pads_s;
            drift_r       <= drift_s;
            death_cnt_r   <= death_cnt_s;
            sw_r          <= sw_s;
            level_clear_r <= level_clear_s;
            dying_r       <= (state_s == ST_DYING);
            game_over_r   <= (state_s == ST_GAME_OVER);
        end
    end

    assign o_Frogger_X   = x_r;
    assign o_Frogger_Y   = y_r;
    assign o_Score       = score_r;
    assign o_Lives       = lives_r;
    assign o_Pads_Filled = pads_r;
    assign o_Dying       = dying_r;
    assign o_Game_Over   = game_over_r;
    assign o_Level_Clear = level_clear_r;

endmodule

// File: tb/tb_frogger_player_ctrl.sv
// Scoreboard bench for frogger_player_ctrl: a game-rule model predicts every cycle's
// outputs into a queue, and a monitor compares them against the DUT.
module tb_frogger_player_ctrl;

    localparam int GRID_W       = 14;
    localparam int GRID_H       = 15;
    localparam int START_X      = 10;
    localparam int START_Y      = 14;
    localparam int N_LIVES      = 3;
    localparam int N_PADS       = 5;
    localparam int DRIFT_DIV    = 4;
    localparam int DEATH_CYCLES = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, act, up, dn, lf, rt, col, onlog, dir;
    logic [3:0] tile;
    logic [2:0] pidx;
    logic [5:0] o_x, o_y;
    logic [6:0] o_score;
    logic [2:0] o_lives;
    logic [N_PADS-1:0] o_pads;
    logic o_dying, o_over, o_lvl;

    frogger_player_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(START_X), .START_Y(START_Y),
        .N_LIVES(N_LIVES), .N_PADS(N_PADS), .DRIFT_DIV(DRIFT_DIV), .DEATH_CYCLES(DEATH_CYCLES)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Game_Active(act),
        .i_Up_Mvt(up), .i_Down_Mvt(dn), .i_Left_Mvt(lf), .i_Right_Mvt(rt),
        .i_Collided(col), .i_Bitmap_Data(tile), .i_On_Log(onlog), .i_Log_Dir(dir),
        .i_Pad_Idx(pidx), .o_Frogger_X(o_x), .o_Frogger_Y(o_y), .o_Score(o_score),
        .o_Lives(o_lives), .o_Pads_Filled(o_pads), .o_Dying(o_dying),
        .o_Game_Over(o_over), .o_Level_Clear(o_lvl)
    );

    typedef struct {
        int x; int y; int score; int lives; int pads;
        bit dying; bit over; bit lvl;
    } exp_t;
    exp_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef enum {M_IDLE, M_PLAY, M_DYING, M_OVER} mode_t;
    mode_t mode;
    int fx, fy, score, lives, dying_left, log_time, last_pad;
    bit pad_full[N_PADS];
    bit prev_sw[4];
    bit lvl;

    function automatic void check(string name, int got, int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endfunction

    function automatic int pads_word();
        int w = 0;
        for (int i = 0; i < N_PADS; i++) if (pad_full[i]) w |= (1 << i);
        return w;
    endfunction

    function automatic void model_die();
        lives--;
        dying_left = DEATH_CYCLES;
        mode = M_DYING;
    endfunction

    function automatic void model_new_game();
        fx = START_X; fy = START_Y; score = 0; lives = N_LIVES; log_time = 0;
        for (int i = 0; i < N_PADS; i++) pad_full[i] = 1'b0;
    endfunction

    // Game rules for one clock edge, driven by the inputs currently applied.
    function automatic void model_step();
        bit sw[4];
        bit ed[4];
        bit drift_now;
        int nx, filled;
        sw[0] = up; sw[1] = dn; sw[2] = lf; sw[3] = rt;
        for (int i = 0; i < 4; i++) ed[i] = sw[i] && !prev_sw[i];
        lvl = 1'b0;
        if (rst) begin
            mode = M_IDLE;
            model_new_game();
            for (int i = 0; i < 4; i++) prev_sw[i] = 1'b0;
            return;
        end
        case (mode)
            M_IDLE: if (act) begin model_new_game(); mode = M_PLAY; end
            M_PLAY: begin
                if (!act) mode = M_IDLE;
                else begin
                    drift_now = onlog && (log_time == DRIFT_DIV - 1);
                    log_time  = onlog ? (log_time + 1) % DRIFT_DIV : 0;
                    if (col || (tile == 4'd2 && !onlog)) model_die();
                    else if (fy == 0) begin
                        if (tile == 4'd4 && pidx < N_PADS && !pad_full[pidx]) begin
                            pad_full[pidx] = 1'b1;
                            filled = 0;
                            for (int i = 0; i < N_PADS; i++) filled += int'(pad_full[i]);
                            if (filled == N_PADS) begin
                                lvl = 1'b1;
                                for (int i = 0; i < N_PADS; i++) pad_full[i] = 1'b0;
                            end
                            score = (score + 1 > 127) ? 127 : score + 1;
                            fx = START_X; fy = START_Y;
                        end else model_die();
                    end else if (drift_now) begin
                        nx = dir ? fx + 1 : fx - 1;
                        if (nx < 0 || nx >= GRID_W) model_die();
                        else fx = nx;
                    end else if (ed[0]) fy = (fy > 0) ? fy - 1 : 0;
                    else if (ed[1]) fy = (fy < GRID_H - 1) ? fy + 1 : fy;
                    else if (ed[2]) fx = (fx > 0) ? fx - 1 : 0;
                    else if (ed[3]) fx = (fx < GRID_W - 1) ? fx + 1 : fx;
                end
            end
            M_DYING: begin
                if (!act) mode = M_IDLE;
                else begin
                    dying_left--;
                    if (dying_left == 0) begin
                        if (lives == 0) mode = M_OVER;
                        else begin mode = M_PLAY; fx = START_X; fy = START_Y; log_time = 0; end
                    end
                end
            end
            default: if (!act) mode = M_IDLE;
        endcase
        for (int i = 0; i < 4; i++) prev_sw[i] = sw[i];
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.x = fx; e.y = fy; e.score = score; e.lives = lives; e.pads = pads_word();
        e.dying = (mode == M_DYING); e.over = (mode == M_OVER); e.lvl = lvl;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        model_step();
        push_expect();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0; col = 1'b0;
        tile = 4'd0; onlog = 1'b0; dir = 1'b0; pidx = 3'd0;
    endtask

    task automatic climb();
        int guard = 0;
        while (fy != 0 && mode == M_PLAY && guard < 100) begin
            up = 1'b1; tick(); up = 1'b0; tick(); guard++;
        end
    endtask

    task automatic land_once();
        int free_q[$];
        climb();
        for (int i = 0; i < N_PADS; i++) if (!pad_full[i]) free_q.push_back(i);
        last_pad = (free_q.size() > 0) ? free_q[$urandom_range(0, free_q.size() - 1)] : 0;
        tile = 4'd4; pidx = 3'(last_pad); tick();
        tile = 4'd0; tick();
    endtask

    // Monitor: every cycle's outputs are compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frog_x", int'(o_x), e.x);
                check("frog_y", int'(o_y), e.y);
                check("score", int'(o_score), e.score);
                check("lives", int'(o_lives), e.lives);
                check("pads", int'(o_pads), e.pads);
                check("dying", int'(o_dying), int'(e.dying));
                check("game_over", int'(o_over), int'(e.over));
                check("level_clear", int'(o_lvl), int'(e.lvl));
            end
        end
    end

    initial begin
        rst = 1'b1; act = 1'b0; quiet_inputs();
        mode = M_IDLE; model_new_game(); last_pad = 0; lvl = 1'b0;
        for (int i = 0; i < 4; i++) prev_sw[i] = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0; tick();

        // Three Up pulses, then a held Up that must move only once.
        act = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin up = 1'b1; tick(); up = 1'b0; tick(); end
        up = 1'b1; repeat (4) tick(); up = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin rt = 1'b1; tick(); rt = 1'b0; tick(); end

        // Right-moving log from X=12: one step to 13, then off the edge.
        onlog = 1'b1; dir = 1'b1; tile = 4'd2; repeat (9) tick();
        onlog = 1'b0; tile = 4'd0; repeat (DEATH_CYCLES + 2) tick();

        // Drowning in the same cycle as a Right edge.
        tile = 4'd2; rt = 1'b1; tick();
        tile = 4'd0; rt = 1'b0; repeat (DEATH_CYCLES + 2) tick();

        // Randomised play.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            act = ($urandom_range(0, 99) != 0);
            up = ($urandom_range(0, 3) == 0); dn = ($urandom_range(0, 7) == 0);
            lf = ($urandom_range(0, 5) == 0); rt = ($urandom_range(0, 5) == 0);
            col = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 9))
                0, 1:    tile = 4'd2;
                2:       tile = 4'd4;
                3:       tile = 4'($urandom_range(0, 15));
                default: tile = 4'd0;
            endcase
            onlog = ($urandom_range(0, 2) == 0);
            dir = 1'($urandom_range(0, 1));
            pidx = 3'($urandom_range(0, 7));
            tick();
        end

        // Fill pads repeatedly until the score saturates.
        rst = 1'b1; act = 1'b0; quiet_inputs(); tick();
        rst = 1'b0; act = 1'b1; tick();
        for (int n = 0; n < 131; n++) land_once();

        // Re-land on a filled pad, then reset in the middle of the death freeze.
        climb();
        tile = 4'd4; pidx = 3'(last_pad); tick();
        tile = 4'd0; repeat (3) tick();
        rst = 1'b1; tick();
        rst = 1'b0; act = 1'b0; repeat (2) tick();

        // Three collisions to game over, then back through IDLE to a fresh game.
        act = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            col = 1'b1; tick(); col = 1'b0; repeat (DEATH_CYCLES + 1) tick();
        end
        repeat (3) tick();
        act = 1'b0; repeat (2) tick();
        act = 1'b1; repeat (3) tick();

        quiet_inputs(); repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
